// File: rtl/rsa2048_core_adapter.sv
// rsa2048_core_adapter
// Bridges the 32-bit forward/backward word FIFOs of the RSA-2048 AHB slave
// and the 2048-bit modular-exponentiation core. A start command pops 2*NW
// words into operands A (words 0..NW-1) and B (words NW..2NW-1), launches
// the core, waits for completion, then pushes the NW-word result LSW-first
// and pulses finish.
//
// Ports:
//   HCLK, HRESETn      clock / async active-low reset
//   clr                synchronous abort back to IDLE
//   start              start request (IDLE only)
//   in_rdy/in_vld/in_dat     forward FIFO: word available / pop / head word
//   out_rdy/out_vld/out_dat  backward FIFO: room / push / pushed word
//   op_a, op_b         operand registers to the core
//   core_start         one-cycle core launch pulse
//   core_done/core_res core completion and result
//   busy               high in every state except IDLE
//   finish             one-cycle pulse after the last result word is pushed
module rsa2048_core_adapter #(
  parameter int unsigned DW = 32,
  parameter int unsigned NW = 64
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             clr,
  input  logic             start,
  input  logic             in_rdy,
  output logic             in_vld,
  input  logic [DW-1:0]    in_dat,
  input  logic             out_rdy,
  output logic             out_vld,
  output logic [DW-1:0]    out_dat,
  output logic [NW*DW-1:0] op_a,
  output logic [NW*DW-1:0] op_b,
  output logic             core_start,
  input  logic             core_done,
  input  logic [NW*DW-1:0] core_res,
  output logic             busy,
  output logic             finish
);

  localparam int unsigned CW = $clog2(2 * NW);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LAUNCH,
    S_WAIT,
    S_STORE,
    S_FIN
  } state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [NW*DW-1:0]    r_op_a;
  logic [NW*DW-1:0]    r_op_b;
  logic [NW*DW-1:0]    r_res;
  logic                r_core_start;
  logic                r_busy;
  logic                r_finish;

  logic                w_pop;
  logic                w_push;
  logic                w_is_b;
  logic [CW-1:0]       w_slot;

  // Handshake strobes follow the FIFO flags directly; clr suppresses them.
  assign w_pop  = (r_state == S_LOAD)  && in_rdy  && !clr;
  assign w_push = (r_state == S_STORE) && out_rdy && !clr;

  // Word slot within the selected operand.
  assign w_is_b = (r_cnt >= CW'(NW));
  assign w_slot = w_is_b ? (r_cnt - CW'(NW)) : r_cnt;

  assign in_vld     = w_pop;
  assign out_vld    = w_push;
  assign out_dat    = r_res[DW-1:0];
  assign op_a       = r_op_a;
  assign op_b       = r_op_b;
  assign core_start = r_core_start;
  assign busy       = r_busy;
  assign finish     = r_finish;

  // Control FSM with registered busy/core_start/finish and datapath registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_res        <= '0;
      r_core_start <= 1'b0;
      r_busy       <= 1'b0;
      r_finish     <= 1'b0;
    end else if (clr) begin
      // Abort: operands and result register are deliberately left untouched.
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_core_start <= 1'b0;
      r_busy       <= 1'b0;
      r_finish     <= 1'b0;
    end else begin
      r_core_start <= 1'b0;
      r_finish     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LOAD;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          if (w_pop) begin
            for (int i = 0; i < NW; i++) begin
              if (w_slot == CW'(i)) begin
                if (w_is_b) r_op_b[i*DW +: DW] <= in_dat;
                else        r_op_a[i*DW +: DW] <= in_dat;
              end
            end
            if (r_cnt == CW'(2 * NW - 1)) begin
              r_cnt        <= '0;
              r_state      <= S_LAUNCH;
              r_core_start <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        S_LAUNCH: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (core_done) begin
            r_res   <= core_res;
            r_state <= S_STORE;
          end
        end
        S_STORE: begin
          if (w_push) begin
            r_res <= r_res >> DW;
            if (r_cnt == CW'(NW - 1)) begin
              r_cnt    <= '0;
              r_state  <= S_FIN;
              r_finish <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
